ro_counter: RTL and testbench
=============================

# ro_counter

Measurement front end for the ring oscillator macro. It enables the oscillator, drives its 2-bit delay key, and lets the loop settle. It then counts rising edges of the oscillator output over a programmable window of system-clock cycles and reports a saturating count. It sits between the control/CSR logic and the hand-instantiated RO cell, and is the only block that drives the RO enable and key pins.

## Interface
Parameters:
- GATE_W, 16, width of the gate-window length input
- CNT_W, 16, width of the edge count result
- SETTLE_CYC, 8, clk cycles the RO runs before counting starts (≥3, covers the synchronizer depth)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a measurement; sampled only in IDLE
- key_in  input  2  delay key for single-measurement mode
- gate_cycles  input  GATE_W  window length in clk cycles; sampled with start
- ro_out  input  1  raw oscillator output, asynchronous to clk
- ro_enable  output  1  to RO enable pin
- ro_key  output  2  to RO K pins; registered
- busy  output  1  high from the cycle after start is accepted until DONE is left
- count  output  CNT_W  last result; held until next result
- count_key  output  2  key that produced count
- count_valid  output  1  one-cycle pulse when count updates
- sat  output  1  count saturated during the last window
- done  output  1  one-cycle pulse when the full request completes

## Operation
- ro_out passes through a 2-FF synchronizer, then a rising-edge detector. The resulting edge pulse is the only use of ro_out. This is valid only for f_ro < f_clk/2; the block does not check it.
- FSM states: IDLE, SETTLE, GATE, DONE.
- IDLE: ro_enable=0. On start=1, latch gate_cycles and key_in, load ro_key, go to SETTLE.
- SETTLE: ro_enable=1; run SETTLE_CYC cycles, then clear the edge counter and go to GATE.
- GATE: ro_enable=1; run for gate_cycles cycles. Each edge pulse increments the counter, saturating at 2^CNT_W−1 and setting sat. If gate_cycles=0, spend zero cycles here: count=0, sat=0.
- DONE: ro_enable=0. Load count, count_key and sat; pulse count_valid and done; go to IDLE.
- start while busy=1 is ignored, with no queuing.
- ro_key changes only while ro_enable=0.

## Timing
- Reset values: ro_enable=0, ro_key=0, busy=0, count=0, count_key=0, count_valid=0, sat=0, done=0; FSM in IDLE. Reset is asynchronous; mid-measurement it kills the oscillator immediately and discards the partial count.
- start sampled high in IDLE at edge t:
  - busy=1 and ro_enable=1 from t+1.
  - GATE occupies cycles t+1+SETTLE_CYC … t+SETTLE_CYC+gate_cycles.
  - DONE cycle is t+1+SETTLE_CYC+gate_cycles, with count_valid=done=1 and ro_enable=0.
  - busy=0 at the next cycle.
- Edge pulses reach the counter 3 cycles after the ro_out transition. Only pulses present during GATE cycles are counted, so results are ±1 of the ideal count.
- A new start is accepted in the first IDLE cycle after DONE.

## Configuration
- RO_COUNTER_SWEEP_EN defined: start measures keys 0,1,2,3 back to back; key_in is ignored.
  - Each key runs SETTLE → GATE → one result cycle, with ro_enable=0 and count_valid=1 in the result cycle.
  - ro_key advances during the result cycle, then SETTLE resumes.
  - done pulses only together with the 4th count_valid (key 3).
  - busy stays high throughout; sat is per result.
- Not defined: single measurement at key_in, as described above. count_valid and done coincide.

## Test plan
- Single measurement: SETTLE_CYC=8, key_in=2, gate_cycles=100, RO model toggling every 5 clk cycles (period 10).
  - Expect ro_key=2 and count=10±1, count_key=2, sat=0.
  - done at t+109; exactly one done pulse.
- Start while busy: pulse start again during GATE → ignored; one done only, count unchanged by the second pulse.
- Saturation: CNT_W=4, gate_cycles=200, RO period 4 → count=15, sat=1.
- Zero window: gate_cycles=0 → count=0, sat=0, done at t+1+SETTLE_CYC.
- Reset mid-GATE: assert rst asynchronously → ro_enable, busy and count_valid drop before the next clk edge; count=0, FSM in IDLE; next start works normally.
- Sweep (macro defined): RO model period 6,8,10,12 selected by ro_key, gate_cycles=120.
  - Expect four count_valid pulses with count_key 0..3 and counts 20,15,12,10 (±1).
  - ro_enable=0 in each result cycle; single done coincident with the last pulse.

Source files
------------

// File: rtl/ro_counter.sv
// Ring-oscillator measurement front end: enables and keys the RO, lets it settle, then counts
// synchronized RO rising edges over a gate window. Define RO_COUNTER_SWEEP_EN to sweep keys 0..3 per start.
module ro_counter #(
  parameter int unsigned GATE_W     = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        key_in,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              ro_out,
  output logic              ro_enable,
  output logic [1:0]        ro_key,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic [1:0]        count_key,
  output logic              count_valid,
  output logic              sat,
  output logic              done
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sync_q;
  logic              edge_q;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [GATE_W-1:0] gate_len_q, gate_len_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        key_q, key_d;
  logic              ro_enable_q, ro_enable_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        count_key_q, count_key_d;
  logic              count_valid_q, count_valid_d;
  logic              sat_q, sat_d;
  logic              done_q, done_d;
  logic              last_key;
  logic [1:0]        first_key;

`ifdef RO_COUNTER_SWEEP_EN
  logic unused_key_in;
  assign unused_key_in = ^key_in;
  assign first_key     = 2'd0;
  assign last_key      = (key_q == 2'd3);
`else
  assign first_key     = key_in;
  assign last_key      = 1'b1;
`endif

  // 2-FF synchronizer plus rising-edge detect; edge_q is the only consumer of ro_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], ro_out};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    gate_len_d  = gate_len_q;
    gate_d      = gate_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    key_d       = key_q;
    count_d     = count_q;
    count_key_d = count_key_q;
    sat_d       = sat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          gate_len_d = gate_cycles;
          key_d      = first_key;
          settle_d   = '0;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          gate_d  = gate_len_q;
          state_d = (gate_len_q == '0) ? DONE : GATE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      GATE: begin
        if (edge_q) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
        gate_d = gate_q - GATE_W'(1);
        if (gate_q == GATE_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (last_key) begin
          state_d = IDLE;
        end else begin
          // key changes on the same edge that re-enables the RO, never while it runs
          key_d    = key_q + 2'd1;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE) begin
      count_d     = cnt_d;
      sat_d       = ovf_d;
      count_key_d = key_q;
    end

    ro_enable_d   = (state_d == SETTLE) || (state_d == GATE);
    busy_d        = (state_d != IDLE);
    count_valid_d = (state_d == DONE);
    done_d        = (state_d == DONE) && last_key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      settle_q      <= '0;
      gate_len_q    <= '0;
      gate_q        <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      key_q         <= 2'd0;
      ro_enable_q   <= 1'b0;
      busy_q        <= 1'b0;
      count_q       <= '0;
      count_key_q   <= 2'd0;
      count_valid_q <= 1'b0;
      sat_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      gate_len_q    <= gate_len_d;
      gate_q        <= gate_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      key_q         <= key_d;
      ro_enable_q   <= ro_enable_d;
      busy_q        <= busy_d;
      count_q       <= count_d;
      count_key_q   <= count_key_d;
      count_valid_q <= count_valid_d;
      sat_q         <= sat_d;
      done_q        <= done_d;
    end
  end

  assign ro_enable   = ro_enable_q;
  assign ro_key      = key_q;
  assign busy        = busy_q;
  assign count       = count_q;
  assign count_key   = count_key_q;
  assign count_valid = count_valid_q;
  assign sat         = sat_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ro_counter.sv
// Scoreboard bench for ro_counter: a 16-bit DUT for normal measurements and a 4-bit DUT for saturation.
module tb_ro_counter;

  localparam int S = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT
  logic        start, ro_out, ro_enable, busy, count_valid, sat, done;
  logic [1:0]  key_in, ro_key, count_key;
  logic [15:0] gate_cycles, count;

  // saturation DUT
  logic        s_start, s_ro, s_ro_enable, s_busy, s_count_valid, s_sat, s_done;
  logic [1:0]  s_key, s_ro_key, s_count_key;
  logic [15:0] s_gate;
  logic [3:0]  s_count;

  ro_counter #(.GATE_W(16), .CNT_W(16), .SETTLE_CYC(S)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .gate_cycles(gate_cycles),
    .ro_out(ro_out), .ro_enable(ro_enable), .ro_key(ro_key), .busy(busy), .count(count),
    .count_key(count_key), .count_valid(count_valid), .sat(sat), .done(done)
  );

  ro_counter #(.GATE_W(16), .CNT_W(4), .SETTLE_CYC(S)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .key_in(s_key), .gate_cycles(s_gate),
    .ro_out(s_ro), .ro_enable(s_ro_enable), .ro_key(s_ro_key), .busy(s_busy), .count(s_count),
    .count_key(s_count_key), .count_valid(s_count_valid), .sat(s_sat), .done(s_done)
  );

  // RO models: main period is 6+2*key clk cycles, saturation DUT fixed at 4
  initial begin
    ro_out = 1'b0;
    forever begin
      if (ro_enable === 1'b1) begin
        #((3 + int'(ro_key)) * 10) ro_out = ~ro_out;
      end else begin
        ro_out = 1'b0;
        @(posedge ro_enable);
        #3;
      end
    end
  end

  initial begin
    s_ro = 1'b0;
    forever begin
      if (s_ro_enable === 1'b1) begin
        #20 s_ro = ~s_ro;
      end else begin
        s_ro = 1'b0;
        @(posedge s_ro_enable);
        #3;
      end
    end
  end

  typedef struct {
    int lo;
    int hi;
    int key;
    int satv;
    int donev;
    int at;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t em, es;
  int errors = 0;
  int checks = 0;
  int n_done_m = 0, n_done_s = 0, exp_done_m = 0, exp_done_s = 0;

  task automatic chk(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    end
  endtask

  // monitor: pop an expectation whenever a DUT presents count_valid
  always @(negedge clk) begin
    if (!rst) begin
      if (done) n_done_m++;
      if (s_done) n_done_s++;
      if (done && !count_valid) chk("m_done_without_valid", 1, 0, 0);
      if (s_done && !s_count_valid) chk("s_done_without_valid", 1, 0, 0);
      if (count_valid) begin
        if (q_m.size() == 0) begin
          chk("m_unexpected_valid", 1, 0, 0);
        end else begin
          em = q_m.pop_front();
          chk("m_count", int'(count), em.lo, em.hi);
          chk("m_count_key", int'(count_key), em.key, em.key);
          chk("m_sat", int'(sat), em.satv, em.satv);
          chk("m_done", int'(done), em.donev, em.donev);
          chk("m_valid_cycle", cyc, em.at, em.at);
          chk("m_ro_enable_in_result", int'(ro_enable), 0, 0);
          chk("m_busy_in_result", int'(busy), 1, 1);
        end
      end
      if (s_count_valid) begin
        if (q_s.size() == 0) begin
          chk("s_unexpected_valid", 1, 0, 0);
        end else begin
          es = q_s.pop_front();
          chk("s_count", int'(s_count), es.lo, es.hi);
          chk("s_count_key", int'(s_count_key), es.key, es.key);
          chk("s_sat", int'(s_sat), es.satv, es.satv);
          chk("s_done", int'(s_done), es.donev, es.donev);
          chk("s_valid_cycle", cyc, es.at, es.at);
          chk("s_ro_enable_in_result", int'(s_ro_enable), 0, 0);
        end
      end
    end
  end

  // t returns the index of the clock edge that accepted start
  task automatic go_m(input int key, input int gate, input int exp_key, output int t);
    @(negedge clk);
    start = 1'b1; key_in = 2'(key); gate_cycles = 16'(gate);
    t = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("m_busy_after_start", int'(busy), 1, 1);
    chk("m_ro_enable_after_start", int'(ro_enable), 1, 1);
    chk("m_ro_key_after_start", int'(ro_key), exp_key, exp_key);
  endtask

  task automatic go_s(input int key, input int gate, input int exp_key, output int t);
    @(negedge clk);
    s_start = 1'b1; s_key = 2'(key); s_gate = 16'(gate);
    t = cyc + 1;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_busy_after_start", int'(s_busy), 1, 1);
    chk("s_ro_key_after_start", int'(s_ro_key), exp_key, exp_key);
  endtask

  task automatic exp_m(input int t, input int key, input int gate, input int lo, input int hi, input int satv);
    q_m.push_back('{lo, hi, key, satv, 1, t + S + gate});
    exp_done_m++;
  endtask

  task automatic exp_s(input int t, input int key, input int gate, input int lo, input int hi, input int satv);
    q_s.push_back('{lo, hi, key, satv, 1, t + S + gate});
    exp_done_s++;
  endtask

  task automatic push_sweep_m(input int t, input int gate);
    for (int k = 0; k < 4; k++) begin
      int ideal;
      ideal = gate / (6 + 2 * k);
      q_m.push_back('{ideal - 1, ideal + 1, k, 0, (k == 3) ? 1 : 0, t + k * (1 + S + gate) + S + gate});
    end
    exp_done_m++;
  endtask

  task automatic push_sweep_s(input int t, input int gate);
    for (int k = 0; k < 4; k++) begin
      q_s.push_back('{15, 15, k, 1, (k == 3) ? 1 : 0, t + k * (1 + S + gate) + S + gate});
    end
    exp_done_s++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q_m.size() != 0 || q_s.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q_m.size() != 0 || q_s.size() != 0) chk("drain_timeout", 1, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; key_in = 2'd0; gate_cycles = '0;
    s_start = 1'b0; s_key = 2'd0; s_gate = '0;
    repeat (2) @(negedge clk);
    chk("rst_ro_enable", int'(ro_enable), 0, 0);
    chk("rst_ro_key", int'(ro_key), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_count", int'(count), 0, 0);
    chk("rst_count_key", int'(count_key), 0, 0);
    chk("rst_count_valid", int'(count_valid), 0, 0);
    chk("rst_sat", int'(sat), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_s_busy", int'(s_busy), 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef RO_COUNTER_SWEEP_EN
    go_m(3, 120, 0, t);
    push_sweep_m(t, 120);
    go_s(1, 200, 0, t);
    push_sweep_s(t, 200);
    drain(2000);
`else
    go_m(2, 100, 2, t);
    exp_m(t, 2, 100, 9, 11, 0);
    drain(400);

    go_m(0, 0, 0, t);
    exp_m(t, 0, 0, 0, 0, 0);
    drain(100);

    go_m(1, 80, 1, t);
    exp_m(t, 1, 80, 9, 11, 0);
    repeat (S + 20) @(negedge clk);
    start = 1'b1; key_in = 2'd3; gate_cycles = 16'd5;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_key_held", int'(ro_key), 1, 1);
    drain(300);
    chk("busy_start_not_queued", int'(busy), 0, 0);

    go_s(1, 200, 1, t);
    exp_s(t, 1, 200, 15, 15, 1);
    drain(400);
    go_s(2, 20, 2, t);
    exp_s(t, 2, 20, 4, 6, 0);
    drain(100);
`endif

    // asynchronous reset in the middle of GATE
`ifdef RO_COUNTER_SWEEP_EN
    go_m(3, 100, 0, t);
`else
    go_m(3, 100, 3, t);
`endif
    repeat (S + 30) @(negedge clk);
    chk("pre_reset_ro_enable", int'(ro_enable), 1, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ro_enable", int'(ro_enable), 0, 0);
    chk("arst_busy", int'(busy), 0, 0);
    chk("arst_count_valid", int'(count_valid), 0, 0);
    chk("arst_count", int'(count), 0, 0);
    chk("arst_sat", int'(sat), 0, 0);
    chk("arst_done", int'(done), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle_busy", int'(busy), 0, 0);
    chk("post_reset_idle_ro_enable", int'(ro_enable), 0, 0);

`ifdef RO_COUNTER_SWEEP_EN
    go_m(2, 120, 0, t);
    push_sweep_m(t, 120);
    drain(2000);
`else
    go_m(2, 50, 2, t);
    exp_m(t, 2, 50, 4, 6, 0);
    drain(200);
`endif

    repeat (3) @(negedge clk);
    chk("m_done_pulses", n_done_m, exp_done_m, exp_done_m);
    chk("s_done_pulses", n_done_s, exp_done_s, exp_done_s);
    chk("m_queue_empty", q_m.size(), 0, 0);
    chk("s_queue_empty", q_s.size(), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
